// File: rtl/rc4_prga_engine_pkg.sv
// Shared types and helpers for the RC4 keystream engine: FSM state encoding,
// plaintext character bounds and the plaintext validity test.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INC_I   = 4'd1,
    ST_READ_SI = 4'd2,
    ST_READ_SJ = 4'd3,
    ST_WR_SI   = 4'd4,
    ST_WR_SJ   = 4'd5,
    ST_READ_F  = 4'd6,
    ST_WR_OUT  = 4'd7,
    ST_DONE    = 4'd8
  } state_t;

  localparam logic [7:0] PT_LO    = 8'h61;
  localparam logic [7:0] PT_HI    = 8'h7A;
  localparam logic [7:0] PT_SPACE = 8'h20;

  function automatic logic is_valid_char(input logic [7:0] c);
    return ((c >= PT_LO) && (c <= PT_HI)) || (c == PT_SPACE);
  endfunction

endpackage

// File: rtl/rc4_prga_engine_if.sv
// Memory-side bus of the RC4 engine: S-RAM, ciphertext ROM and answer RAM.
// All reads have one cycle of synchronous latency; writes land on the rising edge.
interface rc4_prga_engine_if #(
  parameter int MSG_ADDR_W = 5,
  parameter int S_ADDR_W   = 8
);
  logic [S_ADDR_W-1:0]   s_addr;
  logic [S_ADDR_W-1:0]   s_wdata;
  logic                  s_wren;
  logic [S_ADDR_W-1:0]   s_rdata;
  logic [MSG_ADDR_W-1:0] k_addr;
  logic [7:0]            k_rdata;
  logic [MSG_ADDR_W-1:0] a_addr;
  logic [7:0]            a_wdata;
  logic                  a_wren;

  modport master (
    output s_addr, s_wdata, s_wren, k_addr, a_addr, a_wdata, a_wren,
    input  s_rdata, k_rdata
  );

  modport slave (
    input  s_addr, s_wdata, s_wren, k_addr, a_addr, a_wdata, a_wren,
    output s_rdata, k_rdata
  );
endinterface

// File: rtl/rc4_prga_engine_start_edge.sv
// Registered rising-edge detector for the run request; rise is high for the
// single cycle in which start is high and was low on the previous edge.
module rc4_start_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic rise
);
  logic start_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) start_q <= 1'b0;
    else          start_q <= start;
  end

  assign rise = start & ~start_q;
endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA engine: 7-cycle per-byte walk over S-RAM, XOR with ciphertext, write plaintext.
// Optional abort on non-plaintext bytes when RC4_VALID_CHECK_EN is defined.
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int MAX_MSG_LEN = 32,
  parameter int MSG_ADDR_W  = $clog2(MAX_MSG_LEN),
  parameter int S_ADDR_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [MSG_ADDR_W:0] msg_len,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output state_t              dbg_state_o,
  rc4_prga_engine_if.master   mem
);
  localparam logic [MSG_ADDR_W:0] LEN_MAX = (MSG_ADDR_W+1)'(MAX_MSG_LEN);

  state_t                state_q, state_d;
  logic [S_ADDR_W-1:0]   i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_ADDR_W-1:0] k_q, k_d;
  logic [MSG_ADDR_W:0]   len_q, len_d;
  logic                  start_rise;
  logic [7:0]            pt_byte;
  logic                  last_byte;
  logic                  abort;

  rc4_start_edge u_start_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .rise    (start_rise)
  );

  assign pt_byte   = 8'(mem.s_rdata) ^ mem.k_rdata;
  assign last_byte = ({1'b0, k_q} == (len_q - (MSG_ADDR_W+1)'(1)));
  assign mem.k_addr = k_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

`ifdef RC4_VALID_CHECK_EN
  logic fail_q, fail_d;
  assign abort = !is_valid_char(pt_byte);
  assign fail  = fail_q;
`else
  assign abort = 1'b0;
  assign fail  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      len_q   <= '0;
`ifdef RC4_VALID_CHECK_EN
      fail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      len_q   <= len_d;
`ifdef RC4_VALID_CHECK_EN
      fail_q  <= fail_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    k_d         = k_q;
    len_d       = len_q;
`ifdef RC4_VALID_CHECK_EN
    fail_d      = fail_q;
`endif
    mem.s_addr  = '0;
    mem.s_wdata = '0;
    mem.s_wren  = 1'b0;
    mem.a_addr  = '0;
    mem.a_wdata = '0;
    mem.a_wren  = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          len_d   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
`ifdef RC4_VALID_CHECK_EN
          fail_d  = 1'b0;
`endif
          state_d = (msg_len == '0) ? ST_DONE : ST_INC_I;
        end
      end
      ST_INC_I: begin
        i_d        = i_q + S_ADDR_W'(1);
        mem.s_addr = i_q + S_ADDR_W'(1);
        state_d    = ST_READ_SI;
      end
      // S[i] arrives here; j is advanced and S[j] requested in the same cycle.
      ST_READ_SI: begin
        si_d       = mem.s_rdata;
        j_d        = j_q + mem.s_rdata;
        mem.s_addr = j_q + mem.s_rdata;
        state_d    = ST_READ_SJ;
      end
      ST_READ_SJ: begin
        sj_d    = mem.s_rdata;
        state_d = ST_WR_SI;
      end
      ST_WR_SI: begin
        mem.s_addr  = i_q;
        mem.s_wdata = sj_q;
        mem.s_wren  = 1'b1;
        state_d     = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        mem.s_addr  = j_q;
        mem.s_wdata = si_q;
        mem.s_wren  = 1'b1;
        state_d     = ST_READ_F;
      end
      ST_READ_F: begin
        mem.s_addr = si_q + sj_q;
        state_d    = ST_WR_OUT;
      end
      // The byte is always written; an invalid byte only ends the run afterwards.
      ST_WR_OUT: begin
        mem.a_addr  = k_q;
        mem.a_wdata = pt_byte;
        mem.a_wren  = 1'b1;
        if (last_byte || abort) begin
`ifdef RC4_VALID_CHECK_EN
          fail_d = abort;
`endif
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MSG_ADDR_W'(1);
          state_d = ST_INC_I;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_rc4_prga_engine.sv
// Directed bench for rc4_prga_engine: behavioural S-RAM / ROM / answer RAM,
// hand-computed RC4 vectors, latency and write-count checks.
module tb_rc4_prga_engine;
  import rc4_pkg::*;

  localparam int MAX_MSG_LEN = 32;
  localparam int MSG_ADDR_W  = 5;
  localparam int S_ADDR_W    = 8;

  logic                clk     = 1'b0;
  logic                reset_n = 1'b0;
  logic                start   = 1'b0;
  logic [MSG_ADDR_W:0] msg_len = '0;
  logic                busy, done, fail;
  state_t              dbg_state;
  logic                load_s  = 1'b0;

  logic [7:0] s_mem [256];
  logic [7:0] k_mem [32];
  logic [7:0] a_mem [32];
  logic [7:0] ks    [32];

  int n_cmp = 0;
  int n_err = 0;
  int done_cyc, n_awr, n_swr, first_awr;
  logic fail_at_done;

  rc4_prga_engine_if #(.MSG_ADDR_W(MSG_ADDR_W), .S_ADDR_W(S_ADDR_W)) mem_if ();

  rc4_prga_engine #(
    .MAX_MSG_LEN (MAX_MSG_LEN),
    .MSG_ADDR_W  (MSG_ADDR_W),
    .S_ADDR_W    (S_ADDR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .msg_len     (msg_len),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .dbg_state_o (dbg_state),
    .mem         (mem_if.master)
  );

  // clock / memories
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_s) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      for (int x = 0; x < 32; x++)  a_mem[x] <= 8'h00;
    end else begin
      if (mem_if.s_wren) s_mem[mem_if.s_addr] <= mem_if.s_wdata;
      if (mem_if.a_wren) a_mem[mem_if.a_addr] <= mem_if.a_wdata;
    end
    mem_if.s_rdata <= s_mem[mem_if.s_addr];
    mem_if.k_rdata <= k_mem[mem_if.k_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_identity();
    @(negedge clk);
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
  endtask

  // Reference RC4 PRGA over an identity S, first 32 keystream bytes.
  task automatic ref_ks();
    logic [7:0] ms [256];
    logic [7:0] ri, rj, t;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    ri = 8'h00;
    rj = 8'h00;
    for (int n = 0; n < 32; n++) begin
      ri     = ri + 8'h01;
      rj     = rj + ms[ri];
      t      = ms[ri];
      ms[ri] = ms[rj];
      ms[rj] = t;
      ks[n]  = ms[8'(ms[ri] + ms[rj])];
    end
  endtask

  // Cycle 0 is the accepting cycle; cycle c is sampled at the c-th following negedge.
  task automatic run(input int len, input int repulse_cyc, input int abort_cyc, input bit hold);
    @(negedge clk);
    msg_len      = (MSG_ADDR_W+1)'(len);
    start        = 1'b1;
    done_cyc     = -1;
    n_awr        = 0;
    n_swr        = 0;
    first_awr    = -1;
    fail_at_done = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (!hold) start = (c == repulse_cyc);
      if (c == abort_cyc) begin
        chk("abort_swren_before", 32'(mem_if.s_wren), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_swren",  32'(mem_if.s_wren), 0);
        chk("abort_saddr",  32'(mem_if.s_addr), 0);
        chk("abort_awren",  32'(mem_if.a_wren), 0);
        chk("abort_busy",   32'(busy), 0);
        chk("abort_state",  32'(dbg_state), 32'(ST_IDLE));
        return;
      end
      if (mem_if.s_wren) n_swr++;
      if (mem_if.a_wren) begin
        if (first_awr < 0) first_awr = c;
        n_awr++;
      end
      if (done) begin
        done_cyc     = c;
        fail_at_done = fail;
        break;
      end
    end
    if (!hold) start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    for (int x = 0; x < 32; x++) k_mem[x] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_done",   32'(done), 0);
    chk("rst_fail",   32'(fail), 0);
    chk("rst_swren",  32'(mem_if.s_wren), 0);
    chk("rst_awren",  32'(mem_if.a_wren), 0);
    chk("rst_saddr",  32'(mem_if.s_addr), 0);
    chk("rst_kaddr",  32'(mem_if.k_addr), 0);
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;

    // two-byte message over identity S
    load_identity();
    k_mem[0] = 8'h63;
    k_mem[1] = 8'h72;
    run(2, 0, 0, 1'b0);
    chk("t1_done_cyc",  32'(done_cyc), 15);
    chk("t1_first_awr", 32'(first_awr), 7);
    chk("t1_n_awr",     32'(n_awr), 2);
    chk("t1_n_swr",     32'(n_swr), 4);
    chk("t1_fail",      32'(fail_at_done), 0);
    chk("t1_a0",        32'(a_mem[0]), 32'h61);
    chk("t1_a1",        32'(a_mem[1]), 32'h77);
    chk("t1_s2",        32'(s_mem[2]), 3);
    chk("t1_s3",        32'(s_mem[3]), 2);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 0);

    // start re-pulsed mid-run is ignored
    load_identity();
    run(2, 5, 0, 1'b0);
    chk("rp_done_cyc", 32'(done_cyc), 15);
    chk("rp_n_awr",    32'(n_awr), 2);
    chk("rp_a1",       32'(a_mem[1]), 32'h77);

    // zero length
    run(0, 0, 0, 1'b0);
    chk("z_done_cyc", 32'(done_cyc), 1);
    chk("z_n_swr",    32'(n_swr), 0);
    chk("z_n_awr",    32'(n_awr), 0);

    // msg_len above MAX_MSG_LEN clamps to 32 bytes, ciphertext decrypts to 'a'
    load_identity();
    ref_ks();
    for (int n = 0; n < 32; n++) k_mem[n] = ks[n] ^ 8'h61;
    run(40, 0, 0, 1'b0);
    chk("cl_done_cyc", 32'(done_cyc), 225);
    chk("cl_n_awr",    32'(n_awr), 32);
    chk("cl_fail",     32'(fail_at_done), 0);
    for (int n = 0; n < 32; n++) chk($sformatf("cl_a%0d", n), 32'(a_mem[n]), 32'h61);

    // non-plaintext first byte
    load_identity();
    k_mem[0] = 8'h02;
    k_mem[1] = 8'h72;
    run(2, 0, 0, 1'b0);
    chk("vc_a0", 32'(a_mem[0]), 0);
`ifdef RC4_VALID_CHECK_EN
    chk("vc_done_cyc", 32'(done_cyc), 8);
    chk("vc_n_awr",    32'(n_awr), 1);
    chk("vc_fail",     32'(fail_at_done), 1);
    chk("vc_a1",       32'(a_mem[1]), 0);
`else
    chk("vc_done_cyc", 32'(done_cyc), 15);
    chk("vc_n_awr",    32'(n_awr), 2);
    chk("vc_fail",     32'(fail_at_done), 0);
    chk("vc_a1",       32'(a_mem[1]), 32'h77);
`endif

    // start held high across DONE does not restart
    load_identity();
    run(1, 0, 0, 1'b1);
    chk("hold_done_cyc", 32'(done_cyc), 8);
    repeat (3) @(negedge clk);
    chk("hold_busy",  32'(busy), 0);
    chk("hold_state", 32'(dbg_state), 32'(ST_IDLE));
    start = 1'b0;

    // reset during WR_SI, then a clean run from a fresh S
    load_identity();
    k_mem[0] = 8'h63;
    k_mem[1] = 8'h72;
    run(2, 0, 4, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    load_identity();
    run(2, 0, 0, 1'b0);
    chk("rr_done_cyc", 32'(done_cyc), 15);
    chk("rr_a0",       32'(a_mem[0]), 32'h61);
    chk("rr_a1",       32'(a_mem[1]), 32'h77);
    chk("rr_fail",     32'(fail_at_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
